parity_chk_arb: RTL and testbench

PARITY_CHK_ARB -- requirements
Module: parity_chk_arb

---
 rtl/pchk_pkg.sv | 15 +
 rtl/rr_arb.sv | 28 ++
 rtl/parity_chk_arb.sv | 106 ++++++++++
 tb/tb_parity_chk_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pchk_pkg.sv
// Shared defaults and the even-parity helper for the parity checker arbiter.
package pchk_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 3;
    localparam int CW_DEF   = 8;

    // Widest data word the helper accepts; narrower words are zero-padded by the caller.
    localparam int MAX_DW   = 32;

    function automatic logic parity_err(input logic [MAX_DW-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin grant: first set request found scanning from ptr upward, modulo N.
module rr_arb #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // N is a power of two, so the PW-bit add wraps naturally.
            idx = ptr + PW'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_chk_arb.sv
// Round-robin shared even-parity checker with a single registered result slot.
// Optional per-requester saturating error counters under PCHK_ERR_CNT_EN.
module parity_chk_arb
    import pchk_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DW-1:0]        req_data,
    input  logic [NREQ-1:0]           req_par,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      rsp_err
`ifdef PCHK_ERR_CNT_EN
    ,
    input  logic                      clr_cnt,
    output logic [NREQ*CW-1:0]        err_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]     ptr;
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     gidx;
    logic [DW-1:0]     sel_data;
    logic              sel_par;
    logic [MAX_DW-1:0] word_pad;
    logic              acc_err;
    logic              slot_free;
    logic              accept;

    rr_arb #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign slot_free = ~rsp_valid | rsp_ready;
    assign req_ready = rst ? '0 : (grant & {NREQ{slot_free}});
    assign accept    = |req_ready;

    // One-hot grant drives an AND-OR mux rather than a binary index.
    always_comb begin
        gidx     = '0;
        sel_data = '0;
        sel_par  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                gidx = PW'(k);
            end
            sel_data = sel_data | (req_data[k*DW +: DW] & {DW{grant[k]}});
        end
        sel_par = |(req_par & grant);
    end

    always_comb begin
        word_pad           = '0;
        word_pad[DW-1:0]   = sel_data;
        acc_err            = parity_err(word_pad, sel_par);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                ptr       <= gidx + PW'(1);
                rsp_valid <= 1'b1;
                rsp_id    <= gidx;
                rsp_err   <= acc_err;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef PCHK_ERR_CNT_EN
    for (genvar k = 0; k < NREQ; k++) begin : g_cnt
        logic [CW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst || clr_cnt) begin
                cnt <= '0;
            end else if (accept && grant[k] && acc_err && (cnt != '1)) begin
                cnt <= cnt + CW'(1);
            end
        end

        assign err_cnt[k*CW +: CW] = cnt;
    end
`endif

endmodule

// File: tb/tb_parity_chk_arb.sv
// Scoreboard bench for parity_chk_arb; counter scenario runs when PCHK_ERR_CNT_EN is defined.
module tb_parity_chk_arb;

    localparam int NREQ = 4;
    localparam int DW   = 3;
    localparam int CW   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_par;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic                rsp_err;
`ifdef PCHK_ERR_CNT_EN
    logic                clr_cnt;
    logic [NREQ*CW-1:0]  err_cnt;
`endif

    parity_chk_arb #(
        .NREQ (NREQ),
        .DW   (DW),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_par   (req_par),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
`ifdef PCHK_ERR_CNT_EN
        ,
        .clr_cnt   (clr_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic       err;
    } rsp_t;

    rsp_t       q[$];
    logic [1:0] ptr_m;
    int         cnt_m[NREQ];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_grant(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (v[idx]) return 4'(1) << idx;
        end
        return 4'b0000;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [11:0] d, input logic [3:0] p, input logic rr);
        req_valid = v;
        req_data  = d;
        req_par   = p;
        rsp_ready = rr;
    endtask

    // Checks outputs just before the edge, then advances the model as the DUT should.
    task automatic step();
        logic [3:0] g;
        logic [3:0] er;
        logic [1:0] gi;
        logic [2:0] w;
        rsp_t       r;
        @(negedge clk);
        g  = model_grant(req_valid, ptr_m);
        er = (rst || !(q.size() == 0 || rsp_ready)) ? 4'b0000 : g;
        check("req_ready", 64'(req_ready), 64'(er));
        check("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_err", 64'(rsp_err), 64'(q[0].err));
        end
`ifdef PCHK_ERR_CNT_EN
        for (int k = 0; k < NREQ; k++)
            check("err_cnt", 64'(err_cnt[k*CW +: CW]), 64'(cnt_m[k]));
`endif
        if (q.size() != 0 && rsp_ready) r = q.pop_front();
        if (er != 4'b0000) begin
            gi = 2'd0;
            for (int k = 0; k < 4; k++) if (er[k]) gi = 2'(k);
            w     = req_data[gi*DW +: DW];
            r.id  = gi;
            r.err = ^{w, req_par[gi]};
            q.push_back(r);
            ptr_m = gi + 2'd1;
            if (r.err && cnt_m[gi] < 255) cnt_m[gi]++;
        end
`ifdef PCHK_ERR_CNT_EN
        if (clr_cnt) foreach (cnt_m[k]) cnt_m[k] = 0;
`endif
        if (rst) begin
            q.delete();
            ptr_m = 2'd0;
            foreach (cnt_m[k]) cnt_m[k] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000, 12'h000, 4'b0000, 1'b0);
`ifdef PCHK_ERR_CNT_EN
        clr_cnt = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        ptr_m = 2'd0;
        foreach (cnt_m[k]) cnt_m[k] = 0;
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_id", 64'(rsp_id), 64'(0));
        check("rst_err", 64'(rsp_err), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;

        // All requesting, consumer always ready: grants 0,1,2,3,0,...
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, 12'($urandom), 4'($urandom), 1'b1);
            step();
        end

        // Requester 2: 101/0 is clean, 111/0 is an error.
        drive(4'b0100, {3'b000, 3'b101, 3'b000, 3'b000}, 4'b0000, 1'b1);
        step();
        drive(4'b0100, {3'b000, 3'b111, 3'b000, 3'b000}, 4'b0000, 1'b1);
        step();
        drive(4'b0000, 12'h000, 4'b0000, 1'b1);
        step();
        step();

        // Backpressure with a pending result, then release.
        drive(4'b1111, 12'($urandom), 4'($urandom), 1'b1);
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_data = 12'($urandom);
            req_par  = 4'($urandom);
            step();
        end

        // Fairness between requesters 0 and 3.
        for (int i = 0; i < 8; i++) begin
            drive(4'b1001, 12'($urandom), 4'($urandom), 1'b1);
            step();
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 60; i++) begin
            drive(4'($urandom), 12'($urandom), 4'($urandom), 1'($urandom));
            step();
        end

`ifdef PCHK_ERR_CNT_EN
        // Saturation of requester 1, then clear wins over a same-cycle increment.
        for (int i = 0; i < 300; i++) begin
            drive(4'b0010, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b0000, 1'b1);
            step();
        end
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        drive(4'b0000, 12'h000, 4'b0000, 1'b1);
        step();
        drive(4'b0010, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b0000, 1'b0);
        step();
`endif

        // Mid-operation reset with a stalled result pending.
        drive(4'b1111, 12'($urandom), 4'($urandom), 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(4'b1111, 12'($urandom), 4'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) step();
        drive(4'b0000, 12'h000, 4'b0000, 1'b1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
